hub75_scan_ctrl: RTL and testbench

HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

---
 rtl/hub75_pkg.sv | 33 +++
 rtl/hub75_oe_timer.sv | 32 +++
 rtl/hub75_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared state encoding and width derivations for the HUB75 scan controller.
// Widths floor at 1 bit so degenerate parameterisations still elaborate.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_width(input int hpix, input int vpix);
    return clog2_min1(hpix * vpix);
  endfunction

  function automatic int row_width(input int vpix);
    return clog2_min1(vpix / 2);
  endfunction

  function automatic int plane_width(input int bpp);
    return clog2_min1(bpp);
  endfunction

  // Longest DISPLAY run is base << (bpp-1); +1 keeps that value representable.
  function automatic int oe_cnt_width(input int base, input int bpp);
    return clog2_min1(base * (1 << (bpp - 1)) + 1);
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// DISPLAY duration counter: load starts a base_cycles_p << plane cycle run, done marks its last cycle.
// Latency: done is high load-count cycles after load; no backpressure, a new load restarts the run.
module hub75_oe_timer
  import hub75_pkg::*;
#(
  parameter int bpp_p         = 8,
  parameter int base_cycles_p = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [plane_width(bpp_p)-1:0] plane,
  output logic                          done
);

  localparam int cnt_w = oe_cnt_width(base_cycles_p, bpp_p);

  logic [cnt_w-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt_w'(base_cycles_p) << plane;
    end else if (cnt != '0) begin
      cnt <= cnt - cnt_w'(1);
    end
  end

  assign done = (cnt == cnt_w'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: shifts one BCM plane of a row pair, latches it, then lights it for a binary-weighted time.
// Framebuffer read latency is one cycle; panel side has no backpressure, i_enable is honoured only at frame end.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int hpixel_p      = 64,
  parameter int vpixel_p      = 64,
  parameter int bpp_p         = 8,
  parameter int base_cycles_p = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      i_enable,
  output logic [addr_width(hpixel_p, vpixel_p)-1:0] o_rd_addr,
  input  logic [2:0][bpp_p-1:0]                     i_rd_data,
  output logic                                      o_r1,
  output logic                                      o_g1,
  output logic                                      o_b1,
  output logic                                      o_r2,
  output logic                                      o_g2,
  output logic                                      o_b2,
  output logic [row_width(vpixel_p)-1:0]            o_row,
  output logic                                      o_hub_clk,
  output logic                                      o_lat,
  output logic                                      o_oe_n,
  output logic                                      o_frame_done,
  output logic                                      o_busy
);

  localparam int addr_w = addr_width(hpixel_p, vpixel_p);
  localparam int row_w  = row_width(vpixel_p);
  localparam int pln_w  = plane_width(bpp_p);
  localparam int cyc_w  = $clog2(2 * hpixel_p + 3);
  localparam int half   = vpixel_p / 2;

  localparam logic [cyc_w-1:0] shift_last = cyc_w'(2 * hpixel_p + 2);
  localparam logic [cyc_w-1:0] addr_end   = cyc_w'(2 * hpixel_p);
  localparam logic [row_w-1:0] row_last   = row_w'(half - 1);
  localparam logic [pln_w-1:0] plane_last = pln_w'(bpp_p - 1);

  scan_state_e      state, state_d;
  logic [row_w-1:0] row, row_d;
  logic [pln_w-1:0] plane, plane_d;
  logic [cyc_w-1:0] cyc, cyc_d;
  logic             timer_done;
  logic [2:0]       up_q;

  hub75_oe_timer #(
    .bpp_p        (bpp_p),
    .base_cycles_p(base_cycles_p)
  ) u_oe_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == ST_LATCH),
    .plane(plane),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      row   <= '0;
      plane <= '0;
      cyc   <= '0;
    end else begin
      state <= state_d;
      row   <= row_d;
      plane <= plane_d;
      cyc   <= cyc_d;
    end
  end

  always_comb begin
    state_d      = state;
    row_d        = row;
    plane_d      = plane;
    cyc_d        = cyc;
    o_frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable) begin
          state_d = ST_SHIFT;
          row_d   = '0;
          plane_d = '0;
          cyc_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cyc == shift_last) begin
          state_d = ST_LATCH;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc + cyc_w'(1);
        end
      end
      ST_LATCH: state_d = ST_DISPLAY;
      ST_DISPLAY: begin
        if (timer_done) begin
          state_d = ST_SHIFT;
          if (plane != plane_last) begin
            plane_d = plane + pln_w'(1);
          end else begin
            plane_d = '0;
            if (row != row_last) begin
              row_d = row + row_w'(1);
            end else begin
              row_d        = '0;
              o_frame_done = 1'b1;
              if (!i_enable) state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Even SHIFT cycles fetch the upper pixel of column cyc/2, odd ones the lower pixel.
  always_comb begin
    o_rd_addr = '0;
    if (state == ST_SHIFT && cyc < addr_end) begin
      o_rd_addr = addr_w'((int'(row) + (cyc[0] ? half : 0)) * hpixel_p + int'(cyc >> 1));
    end
  end

  assign o_lat  = (state == ST_LATCH);
  assign o_oe_n = (state != ST_DISPLAY);
  assign o_busy = (state != ST_IDLE);

  // Upper bits wait one cycle in up_q so both halves reach the pins together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_q      <= '0;
      o_hub_clk <= 1'b0;
      o_row     <= '0;
      {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2} <= '0;
    end else if (state_d == ST_IDLE) begin
      o_hub_clk <= 1'b0;
      o_row     <= '0;
      {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2} <= '0;
    end else begin
      o_hub_clk <= (state == ST_SHIFT) && cyc[0] && (cyc >= cyc_w'(3))
                   && (cyc <= cyc_w'(2 * hpixel_p + 1));
      if (state == ST_SHIFT && cyc[0] && cyc < addr_end) begin
        up_q <= {i_rd_data[0][plane], i_rd_data[1][plane], i_rd_data[2][plane]};
      end
      if (state == ST_SHIFT && !cyc[0] && cyc >= cyc_w'(2) && cyc <= addr_end) begin
        {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2} <=
          {up_q, i_rd_data[0][plane], i_rd_data[1][plane], i_rd_data[2][plane]};
      end
      if (state == ST_SHIFT && state_d == ST_LATCH) begin
        o_row <= row;
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: random framebuffer and enable, per-cycle model from frame-timing arithmetic,
// plus a table of hand-computed spot checks and reset / enable-drop sequences.
module tb_hub75_scan_ctrl;

  localparam int H         = 64;
  localparam int V         = 64;
  localparam int BPP       = 8;
  localparam int BASE      = 1;
  localparam int HALF      = V / 2;
  localparam int SHIFT_LEN = 2 * H + 3;
  localparam int ROW_LEN   = BPP * (SHIFT_LEN + 1) + BASE * ((1 << BPP) - 1);
  localparam int FRAME_LEN = HALF * ROW_LEN;
  localparam int MAX_BAD   = 50;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_enable = 1'b0;
  logic [11:0]          o_rd_addr;
  logic [2:0][BPP-1:0]  i_rd_data = '0;
  logic                 o_r1, o_g1, o_b1, o_r2, o_g2, o_b2;
  logic [4:0]           o_row;
  logic                 o_hub_clk, o_lat, o_oe_n, o_frame_done, o_busy;

  hub75_scan_ctrl #(
    .hpixel_p(H), .vpixel_p(V), .bpp_p(BPP), .base_cycles_p(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_r1(o_r1), .o_g1(o_g1), .o_b1(o_b1),
    .o_r2(o_r2), .o_g2(o_g2), .o_b2(o_b2),
    .o_row(o_row), .o_hub_clk(o_hub_clk), .o_lat(o_lat), .o_oe_n(o_oe_n),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [9:0] mask;
    logic [9:0] exp;
    int         addr;
  } vec_t;

  vec_t        vec [16];
  int          nvec = 0;
  logic [23:0] fb [H*V];
  int          total = 0;
  int          bad = 0;
  int          gcyc = 0;
  int          prev_addr = 0;
  bit          m_busy = 0;
  int          m_t = 0;
  int          m_frame = 0;
  logic        oe_prev = 1'b1;
  logic        lat_prev = 1'b0;
  int          run_len = 0;
  int          run_idx = 0;
  int          last_done = -1;
  int          done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, gcyc, act, exp);
    end
  endtask

  task automatic add_vec(input int t, input logic [9:0] mask, input logic [9:0] exp, input int addr);
    vec[nvec] = '{t, mask, exp, addr};
    nvec++;
  endtask

  task automatic model_advance(input logic en, input logic rst);
    if (!rst) begin
      m_busy = 0;
      m_t = 0;
    end else if (!m_busy) begin
      if (en) begin
        m_busy = 1;
        m_t = 0;
        m_frame++;
      end
    end else if (m_t == FRAME_LEN - 1) begin
      if (en) begin
        m_t = 0;
        m_frame++;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_t++;
    end
  endtask

  // Frame time -> (row, plane, offset within that plane's SHIFT+LATCH+DISPLAY segment).
  task automatic decode(input int t, output int row, output int p, output int o, output int seg);
    int r;
    row = t / ROW_LEN;
    r   = t % ROW_LEN;
    p   = 0;
    while (r >= SHIFT_LEN + 1 + (BASE << p)) begin
      r -= SHIFT_LEN + 1 + (BASE << p);
      p++;
    end
    o   = r;
    seg = SHIFT_LEN + 1 + (BASE << p);
  endtask

  task automatic check_cycle();
    int row, p, o, seg, k;
    bit shift, latch, disp;
    logic [23:0] up, lo;
    if (!m_busy) begin
      chk("idle_busy", o_busy, 0);
      chk("idle_oe_n", o_oe_n, 1);
      chk("idle_lat", o_lat, 0);
      chk("idle_hub_clk", o_hub_clk, 0);
      chk("idle_frame_done", o_frame_done, 0);
      chk("idle_row", o_row, 0);
      chk("idle_rd_addr", o_rd_addr, 0);
      chk("idle_data", {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2}, 0);
      return;
    end
    decode(m_t, row, p, o, seg);
    shift = (o < SHIFT_LEN);
    latch = (o == SHIFT_LEN);
    disp  = (o > SHIFT_LEN);
    chk("busy", o_busy, 1);
    chk("lat", o_lat, latch);
    chk("oe_n", o_oe_n, !disp);
    chk("hub_clk", o_hub_clk, shift && o >= 4 && (o % 2) == 0);
    chk("frame_done", o_frame_done, disp && o == seg - 1 && p == BPP - 1 && row == HALF - 1);
    if (latch || disp) chk("row", o_row, row);
    if (shift && o < 2 * H) chk("rd_addr", o_rd_addr, ((o % 2) ? (row + HALF) * H : row * H) + o / 2);
    if (shift && o >= 3) begin
      k  = (o - 3) / 2;
      up = fb[row * H + k];
      lo = fb[(row + HALF) * H + k];
      chk("data", {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2},
          {up[p], up[BPP + p], up[2 * BPP + p], lo[p], lo[BPP + p], lo[2 * BPP + p]});
    end
  endtask

  task automatic check_vectors();
    logic [9:0] act;
    if (!(m_busy && m_frame == 1)) return;
    act = {o_frame_done, o_oe_n, o_lat, o_hub_clk, o_r1, o_g1, o_b1, o_r2, o_g2, o_b2};
    for (int i = 0; i < nvec; i++) begin
      if (vec[i].t == m_t) begin
        chk($sformatf("vec%0d_t%0d", i, vec[i].t), act & vec[i].mask, vec[i].exp & vec[i].mask);
        if (vec[i].addr >= 0) chk($sformatf("vec%0d_addr", i), o_rd_addr, vec[i].addr);
      end
    end
  endtask

  task automatic monitors();
    if (o_oe_n === 1'b0) begin
      if (oe_prev === 1'b1) chk("lat_before_oe", lat_prev, 1);
      run_len++;
    end else if (oe_prev === 1'b0) begin
      chk("oe_run_len", run_len, BASE << (run_idx % BPP));
      run_idx++;
      run_len = 0;
    end
    oe_prev  = o_oe_n;
    lat_prev = o_lat;
    if (o_frame_done === 1'b1) begin
      if (last_done >= 0) chk("frame_period", gcyc - last_done, 41952);
      last_done = gcyc;
      done_count++;
    end
  endtask

  task automatic step(input logic en, input logic rst);
    i_enable = en;
    rst_n    = rst;
    model_advance(en, rst);
    @(posedge clk);
    #1;
    gcyc++;
    i_rd_data = fb[prev_addr];
    prev_addr = int'(o_rd_addr);
    check_cycle();
    check_vectors();
    monitors();
  endtask

  initial begin
    int row, p, o, seg;
    for (int a = 0; a < H * V; a++) fb[a] = 24'($urandom);
    fb[0]    = 24'h0000FF;
    fb[2053] = 24'h000100;

    // mask/exp bits: done oe_n lat hclk r1 g1 b1 r2 g2 b2
    add_vec(0,     10'b1111000000, 10'b0100000000, 0);
    add_vec(1,     10'b1111000000, 10'b0100000000, 2048);
    add_vec(3,     10'b0001000000, 10'b0000000000, 2049);
    add_vec(4,     10'b0001111000, 10'b0001100000, 2);
    add_vec(14,    10'b0001000010, 10'b0001000010, 7);
    add_vec(130,   10'b0011000000, 10'b0001000000, -1);
    add_vec(131,   10'b1111000000, 10'b0110000000, -1);
    add_vec(132,   10'b1111000000, 10'b0000000000, -1);
    add_vec(133,   10'b1111000000, 10'b0100000000, 0);
    add_vec(137,   10'b0001111000, 10'b0001100000, 2);
    add_vec(147,   10'b0001000010, 10'b0001000000, 7);
    add_vec(1310,  10'b1100000000, 10'b0000000000, -1);
    add_vec(1311,  10'b0111000000, 10'b0100000000, 64);
    add_vec(41950, 10'b1100000000, 10'b0000000000, -1);
    add_vec(41951, 10'b1100000000, 10'b1000000000, -1);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);

    // Frame 1: enable toggles randomly mid-frame but is high at frame end.
    step(1'b1, 1'b1);
    for (int i = 0; i < FRAME_LEN && bad <= MAX_BAD; i++)
      step((m_t == FRAME_LEN - 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
    chk("frame2_started", m_busy && m_frame == 2 && o_busy === 1'b1 && o_rd_addr == 0, 1);

    // Frame 2: enable dropped from row 10 onward; the frame must still finish.
    for (int i = 0; i < FRAME_LEN && bad <= MAX_BAD; i++) begin
      decode(m_t, row, p, o, seg);
      step(row < 10, 1'b1);
    end
    for (int i = 0; i < 30 && bad <= MAX_BAD; i++) step(1'b0, 1'b1);
    chk("drop_idle_busy", o_busy, 0);
    chk("drop_idle_oe_n", o_oe_n, 1);
    chk("done_count", done_count, 2);
    chk("oe_runs", run_idx, 2 * HALF * BPP);

    // Reset landing on the LATCH cycle must leave no latch pulse behind.
    if (bad <= MAX_BAD) begin
      step(1'b1, 1'b1);
      for (int i = 0; i < SHIFT_LEN; i++) step(1'b0, 1'b1);
      chk("pre_reset_lat", o_lat, 1);
      step(1'b0, 1'b0);
      chk("reset_abort_lat", o_lat, 0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
      chk("reset_abort_busy", o_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
